// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and widths for the fetch/data SRAM port arbiter.
// Pure declarations: no latency, no flow control.
// Imported by the arbiter top and its optional fetch buffer.
package sram_port_arbiter_pkg;

    localparam int INS_ADDR   = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] FETCH_SEL = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_MEM  = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_arb_ibuf.sv
// One-entry fetch buffer {valid, word addr, instr}; present only with SRAM_ARB_IBUF_EN.
// Latency: hit is combinational on the lookup address; fill/invalidate take one edge.
// Backpressure: none; a matching store in flight suppresses the hit.
`ifdef SRAM_ARB_IBUF_EN
module sram_arb_ibuf
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = INS_ADDR,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-3:0] lookup_addr,
    input  logic              fill_vld,
    input  logic [ADDR_W-3:0] fill_addr,
    input  logic [DATA_W-1:0] fill_instr,
    input  logic              st_req,
    input  logic              st_launch,
    input  logic [ADDR_W-3:0] st_addr,
    output logic              hit,
    output logic [DATA_W-1:0] instr
);

    logic              valid;
    logic [ADDR_W-3:0] buf_addr;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid    <= 1'b0;
            buf_addr <= '0;
            instr    <= '0;
        end else if (fill_vld) begin
            valid    <= 1'b1;
            buf_addr <= fill_addr;
            instr    <= fill_instr;
        end else if (st_launch && (st_addr == buf_addr)) begin
            valid    <= 1'b0;
        end
    end

    // A store to the buffered word that is about to launch must not be bypassed.
    assign hit = valid && (lookup_addr == buf_addr) && !(st_req && (st_addr == buf_addr));

endmodule
`endif

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and data ports; data side has priority. Option: SRAM_ARB_IBUF_EN.
// Latency: request cycle 0, sram_req cycle 1, done/stall-low cycle 2 with zero-wait ack; +1 per wait state.
// Backpressure: sram_req held until sram_ack; stall requests held while a requester is unserved.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = INS_ADDR,
    parameter int DATA_W = DATA_WIDTH,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall_req,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall_req,
    output logic              sram_req,
    output logic              sram_we,
    output logic [SEL_W-1:0]  sram_sel,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack
);

    arb_state_t        state;
    logic              if_done;
    logic              mem_done;
    logic [DATA_W-1:0] if_rdata_q;
    logic              ibuf_hit;
    logic              mem_launch;
    logic              if_launch;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], mem_addr[1:0]};

    // A data request already served this DONE cycle is not pending again.
    assign mem_launch = mem_req && !mem_done && ((state == ARB_IDLE) || (state == ARB_DONE));
    assign if_launch  = (state == ARB_IDLE) && !mem_req && if_req && !ibuf_hit;

`ifdef SRAM_ARB_IBUF_EN
    logic [DATA_W-1:0] ibuf_instr;

    sram_arb_ibuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (if_addr[ADDR_W-1:2]),
        .fill_vld    ((state == ARB_IF) && sram_ack && if_req),
        .fill_addr   (sram_addr[ADDR_W-1:2]),
        .fill_instr  (sram_rdata),
        .st_req      (mem_req && mem_we),
        .st_launch   (mem_launch && mem_we),
        .st_addr     (mem_addr[ADDR_W-1:2]),
        .hit         (ibuf_hit),
        .instr       (ibuf_instr)
    );

    assign if_rdata = ibuf_hit ? ibuf_instr : if_rdata_q;
`else
    assign ibuf_hit = 1'b0;
    assign if_rdata = if_rdata_q;
`endif

    assign if_stall_req  = if_req && !if_done && !ibuf_hit;
    assign mem_stall_req = mem_req && !mem_done;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ARB_IDLE;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            if_rdata_q <= '0;
            mem_rdata  <= '0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_sel   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            unique case (state)
                ARB_IDLE, ARB_DONE: begin
                    if (mem_launch) begin
                        state      <= ARB_MEM;
                        sram_req   <= 1'b1;
                        sram_we    <= mem_we;
                        sram_sel   <= mem_sel;
                        sram_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        sram_wdata <= mem_wdata;
                    end else if (if_launch) begin
                        state      <= ARB_IF;
                        sram_req   <= 1'b1;
                        sram_we    <= 1'b0;
                        sram_sel   <= FETCH_SEL;
                        sram_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                        sram_wdata <= '0;
                    end else begin
                        state      <= ARB_IDLE;
                    end
                end
                ARB_IF: begin
                    if (sram_ack) begin
                        state    <= ARB_DONE;
                        sram_req <= 1'b0;
                        // A withdrawn fetch still completes but its result is dropped.
                        if (if_req) begin
                            if_rdata_q <= sram_rdata;
                            if_done    <= 1'b1;
                        end
                    end
                end
                ARB_MEM: begin
                    if (sram_ack) begin
                        state    <= ARB_DONE;
                        sram_req <= 1'b0;
                        if (mem_req) begin
                            if (!sram_we) begin
                                mem_rdata <= sram_rdata;
                            end
                            mem_done <= 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port external SRAM between the instruction-fetch port (pc / en_rom) and the data port (ram_en / wr_en / Bits_Sel) of the 5-stage core.
- Sequences each access with a req/ack handshake to the SRAM.
- Raises stall requests toward ctrl while a requester's access is outstanding, so the unified-memory core runs with variable-latency memory.

Parameters:
- ADDR_W, 32, address width of both ports and the SRAM.
- DATA_W, 32, data width.
- SEL_W, 4, byte-lane select width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request (driven from en_rom).
- if_addr  in  ADDR_W  fetch address (pc).
- if_rdata  out  DATA_W  fetched instruction.
- if_stall_req  out  1  stall request to ctrl for the fetch side.
- mem_req  in  1  data access request (ram_en).
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  SEL_W  byte lanes (Bits_Sel).
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data.
- mem_stall_req  out  1  stall request to ctrl for the data side.
- sram_req  out  1  SRAM access strobe; held until ack.
- sram_we  out  1  SRAM write enable.
- sram_sel  out  SEL_W  SRAM byte lanes.
- sram_addr  out  ADDR_W  word-aligned SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid with ack.
- sram_ack  in  1  access complete.

Behaviour:
- FSM states: IDLE, IF_ACC, MEM_ACC, DONE.
- Reset: state=IDLE. All sram_* outputs, if_rdata, mem_rdata and done flags are 0.
- Reset mid-access: the in-flight access is abandoned. sram_req is 0 after the reset edge. An ack arriving in IDLE is ignored.
- IDLE transitions:
  - mem_req=1 → MEM_ACC (data side has priority; it is the older instruction).
  - Else if_req=1 → IF_ACC.
  - Else stay in IDLE.
- Access launch: sram_* outputs are registered on the edge that enters IF_ACC/MEM_ACC and held stable until the cycle sram_ack=1.
  - sram_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Fetch: sram_sel=4'b1111, sram_we=0.
  - Data: sram_sel=mem_sel, sram_we=mem_we, sram_wdata=mem_wdata.
- On sram_ack in IF_ACC/MEM_ACC:
  - Read data is captured into if_rdata/mem_rdata (store: mem_rdata unchanged).
  - The matching done flag is set; sram_req drops; next state is DONE.
- DONE: the done flag is a 1-cycle pulse. Next state is IDLE, except a pending mem_req goes directly to MEM_ACC.
- Stall requests (combinational):
  - if_stall_req = if_req & ~if_done.
  - mem_stall_req = mem_req & ~mem_done.
- Latency: zero-wait SRAM (ack in the first cycle of sram_req) gives request cycle 0, sram_req cycle 1, done/stall low cycle 2. Each wait state adds 1 cycle.
- Both sides request together: MEM access first, then IF. The IF stall stays high throughout.
- Requester drops its request mid-access: the SRAM access completes, the result is discarded, and no done pulse is given.
- A fetch whose done pulse coincides with another stage's stall is refetched on the next cycle. This is correct but costs bandwidth (see optional feature).
- Unaligned address bits [1:0] are ignored; byte lanes come only from mem_sel.

Optional Feature:
- Macro: SRAM_ARB_IBUF_EN.
- Defined: a one-entry fetch buffer holds {valid, addr, instr} of the last completed fetch.
  - An if_req whose if_addr matches a valid entry is served from the buffer with no SRAM access. if_rdata is driven from the buffer and if_stall_req=0 in the same cycle.
  - Any store (mem_we=1) whose word address matches invalidates the entry on launch.
  - Reset clears valid.
- Undefined: every fetch goes to SRAM. No buffer registers are present.

Decomposition:
- Shared package / define header holds:
  - state encodings (ARB_IDLE, ARB_IF, ARB_MEM, ARB_DONE);
  - FETCH_SEL constant 4'b1111;
  - width macros reused from the core (Ins_Addr, DataWidth).
- One sub-module, sram_arb_ibuf, holds the optional fetch buffer; instantiated only under SRAM_ARB_IBUF_EN.
- FSM and datapath stay in sram_port_arbiter.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x0000_0104, ack in 1st req cycle with rdata 0x3C01_1234. Expected: sram_addr=0x0000_0104, sel=F; if_rdata=0x3C01_1234 and if_stall_req=0 in cycle 2.
- Wait-state store: mem_req=1, we=1, sel=4'b0011, addr=0x0000_0043, wdata=0xAABB_CCDD, ack after 3 cycles. Expected: sram_addr=0x0000_0040, signals stable 3 cycles, mem_stall_req low the cycle after ack.
- Simultaneous requests: IF (0x200) and MEM load (0x80, rdata 0x55). Expected: MEM served first, if_stall_req high until the IF access (the second one) completes.
- Reset during MEM_ACC: rst_n=1 for 1 cycle, then a late ack. Expected: all outputs 0, ack ignored, next if_req serviced normally.
- Request withdrawn: if_req dropped mid-access. Expected: access completes, if_rdata unchanged, no done pulse.
- IBUF_EN: repeat fetch of 0x104 → no sram_req, if_stall_req=0. A store to 0x104 followed by fetch 0x104 → SRAM access issued.
